demux_1_n: RTL and testbench

- Inverse of the transfer-bus selector. Collects a serial stream of signed fixed-point words, one per accepted handshake.
- Scatters the words into a LEN_TRANSFER-entry register bank indexed by an internal write pointer.
- Presents the whole bank in parallel with a done flag. Holds the bank until the consumer acknowledges.
- Sits between a single-word transfer channel and the parallel transfer bus of the PE array.

---
 rtl/demux_1_n_pkg.sv | 23 ++
 rtl/demux_1_n.sv | 132 +++++++++++++
 tb/tb_demux_1_n.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/demux_1_n_pkg.sv
// Shared types for the serial-to-parallel transfer demux.
// Holds the FILL/FULL state encoding, the signed fixed-point transfer word
// and a helper that sizes index vectors.
package demux_1_n_pkg;

  localparam int unsigned I_WIDTH    = 8;
  localparam int unsigned F_WIDTH    = 8;
  localparam int unsigned WORD_WIDTH = I_WIDTH + F_WIDTH;

  // FILL: collecting words; FULL: bank complete, waiting for the consumer
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  typedef logic signed [WORD_WIDTH-1:0] tr_word_t;

  // Bits needed to index n entries (never less than one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_1_n.sv
// Serial-to-parallel transfer demux.
// Collects one signed fixed-point word per accepted valid/ready handshake into a
// LEN_TRANSFER-entry bank, then presents the whole bank with tr_done_o until the
// consumer acknowledges.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   tr_data_i/valid_i   incoming serial word; tr_ready_o high while filling
//   tr_len_i            frame length, sampled on the first word of a frame
//   tr_flush_i          abort the current frame
//   tr_ack_i            consumer has taken the frame
//   tr_data_o           parallel bank, tr_done_o marks it complete
//   sel_demux_tr_o      current write index
module demux_1_n
  import demux_1_n_pkg::*;
#(
  parameter int unsigned I_WIDTH            = 8,
  parameter int unsigned F_WIDTH            = 8,
  parameter int unsigned LEN_TRANSFER       = 10,
  parameter int unsigned MAX_LEN_TRANSFER   = 10,
  parameter int unsigned SEL_DEMUX_TR_WIDTH = idx_width(MAX_LEN_TRANSFER),
  parameter int unsigned TR_LEN_WIDTH       = $clog2(MAX_LEN_TRANSFER + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic signed [I_WIDTH+F_WIDTH-1:0]   tr_data_i,
  input  logic                                tr_valid_i,
  output logic                                tr_ready_o,
  input  logic [TR_LEN_WIDTH-1:0]             tr_len_i,
  input  logic                                tr_flush_i,
  input  logic                                tr_ack_i,
  output logic signed [I_WIDTH+F_WIDTH-1:0]   tr_data_o [0:LEN_TRANSFER-1],
  output logic                                tr_done_o,
  output logic [SEL_DEMUX_TR_WIDTH-1:0]       sel_demux_tr_o
);

  localparam int unsigned W = I_WIDTH + F_WIDTH;
  localparam logic [TR_LEN_WIDTH-1:0] LEN_MAX = TR_LEN_WIDTH'(LEN_TRANSFER);

  state_e                          state_q, state_d;
  logic [SEL_DEMUX_TR_WIDTH-1:0]   sel_q, sel_d;
  logic [TR_LEN_WIDTH-1:0]         len_q, len_d;
  logic                            done_q, done_d;
  logic signed [W-1:0]             bank_q [0:LEN_TRANSFER-1];
  logic signed [W-1:0]             bank_d [0:LEN_TRANSFER-1];

  logic [TR_LEN_WIDTH-1:0]         len_eff_c;
  logic [TR_LEN_WIDTH-1:0]         cur_len_c;
  logic                            is_last_c;
  logic                            accept_c;

  // Out-of-range lengths (0 or above the bank size) mean "whole bank"
  always_comb begin
    len_eff_c = tr_len_i;
    if ((tr_len_i == '0) || (tr_len_i > LEN_MAX)) begin
      len_eff_c = LEN_MAX;
    end
  end

  // The first word of a frame uses the live length, later words the latched one
  assign cur_len_c = (sel_q == '0) ? len_eff_c : len_q;
  assign is_last_c = (TR_LEN_WIDTH'(sel_q) == (cur_len_c - TR_LEN_WIDTH'(1)));
  assign accept_c  = tr_valid_i && (state_q == FILL);

  // Next-state logic; flush overrides accept and ack
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    done_d  = done_q;
    bank_d  = bank_q;

    if (tr_flush_i) begin
      state_d = FILL;
      sel_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_c) begin
            for (int unsigned i = 0; i < LEN_TRANSFER; i++) begin
              if (sel_q == SEL_DEMUX_TR_WIDTH'(i)) begin
                bank_d[i] = tr_data_i;
              end
            end
            if (sel_q == '0) begin
              len_d = len_eff_c;
            end
            if (is_last_c) begin
              state_d = FULL;
              done_d  = 1'b1;
            end else begin
              sel_d = sel_q + SEL_DEMUX_TR_WIDTH'(1);
            end
          end
        end
        FULL: begin
          if (tr_ack_i) begin
            state_d = FILL;
            sel_d   = '0;
            done_d  = 1'b0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State and bank registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      sel_q   <= '0;
      len_q   <= LEN_MAX;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < LEN_TRANSFER; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      done_q  <= done_d;
      bank_q  <= bank_d;
    end
  end

  assign tr_ready_o     = (state_q == FILL);
  assign tr_done_o      = done_q;
  assign sel_demux_tr_o = sel_q;
  assign tr_data_o      = bank_q;

endmodule

// File: tb/tb_demux_1_n.sv
// Directed bench for demux_1_n with a scoreboard of written bank entries.
module tb_demux_1_n;
  import demux_1_n_pkg::*;

  localparam int LEN = 10;

  logic            clk = 1'b0;
  logic            rst_i;
  tr_word_t        tr_data_i;
  logic            tr_valid_i;
  logic            tr_ready_o;
  logic [3:0]      tr_len_i;
  logic            tr_flush_i;
  logic            tr_ack_i;
  tr_word_t        tr_data_o [0:LEN-1];
  logic            tr_done_o;
  logic [3:0]      sel_demux_tr_o;

  typedef struct {
    int       idx;
    tr_word_t val;
  } sb_t;

  sb_t      sb [$];
  tr_word_t model [LEN];
  tr_word_t wv [LEN];
  int       n_vec = 0;
  int       n_err = 0;

  demux_1_n dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .tr_data_i      (tr_data_i),
    .tr_valid_i     (tr_valid_i),
    .tr_ready_o     (tr_ready_o),
    .tr_len_i       (tr_len_i),
    .tr_flush_i     (tr_flush_i),
    .tr_ack_i       (tr_ack_i),
    .tr_data_o      (tr_data_o),
    .tr_done_o      (tr_done_o),
    .sel_demux_tr_o (sel_demux_tr_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic rdy, input logic done,
                            input int sel);
    chk({tag, "_ready"}, 32'(tr_ready_o), 32'(rdy));
    chk({tag, "_done"}, 32'(tr_done_o), 32'(done));
    chk({tag, "_sel"}, 32'(sel_demux_tr_o), 32'(sel));
  endtask

  // Pop every pending write, then confirm the whole bank matches the model
  task automatic drain(input string tag);
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      model[e.idx] = e.val;
      chk({tag, "_write"}, 32'(tr_data_o[e.idx]), 32'(e.val));
    end
    for (int i = 0; i < LEN; i++) begin
      chk($sformatf("%s_bank%0d", tag, i), 32'(tr_data_o[i]), 32'(model[i]));
    end
  endtask

  // Stream n words; eff is the effective frame length the DUT should use
  task automatic send_words(input int len_in, input int n, input int eff, input bit gap);
    for (int i = 0; i < n; i++) begin
      tr_len_i   = 4'(len_in);
      tr_valid_i = 1'b1;
      tr_data_i  = wv[i];
      sb.push_back('{idx: i, val: wv[i]});
      tick();
      tr_valid_i = 1'b0;
      if (i == eff - 1) chk_status("last", 1'b0, 1'b1, eff - 1);
      else              chk_status("acc", 1'b1, 1'b0, i + 1);
      if (gap) begin
        tick();
        chk("gap_sel", 32'(sel_demux_tr_o), 32'((i == eff - 1) ? eff - 1 : i + 1));
      end
    end
  endtask

  task automatic ack();
    tr_ack_i = 1'b1;
    tick();
    tr_ack_i = 1'b0;
    chk_status("ack", 1'b1, 1'b0, 0);
  endtask

  initial begin
    rst_i = 1'b1; tr_data_i = '0; tr_valid_i = 1'b0; tr_len_i = '0;
    tr_flush_i = 1'b0; tr_ack_i = 1'b0;
    for (int i = 0; i < LEN; i++) model[i] = '0;

    // 1: reset, then a full back-to-back frame of 1..10
    tick(); tick();
    rst_i = 1'b0;
    chk_status("reset", 1'b1, 1'b0, 0);
    drain("reset");
    for (int i = 0; i < LEN; i++) wv[i] = tr_word_t'(i + 1);
    send_words(10, 10, 10, 1'b0);
    drain("full");
    ack();

    // 2: short frame, upper entries keep previous contents
    wv[0] = -16'sd5; wv[1] = 16'sd7; wv[2] = -16'sd128;
    send_words(3, 3, 3, 1'b0);
    drain("short");

    // 3: valid ignored while FULL
    tr_valid_i = 1'b1; tr_data_i = 16'sh7FFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_status("bp", 1'b0, 1'b1, 2);
    end
    tr_valid_i = 1'b0;
    drain("bp");
    ack();

    // 4: gapped full frame
    for (int i = 0; i < LEN; i++) wv[i] = tr_word_t'(i + 1);
    send_words(10, 10, 10, 1'b1);
    drain("gap");
    ack();

    // 5: flush mid-frame with a word presented, then a 2-word frame
    for (int i = 0; i < 4; i++) wv[i] = tr_word_t'(50 + i);
    send_words(10, 4, 10, 1'b0);
    drain("part");
    tr_flush_i = 1'b1; tr_valid_i = 1'b1; tr_data_i = 16'sd99;
    tick();
    tr_flush_i = 1'b0; tr_valid_i = 1'b0;
    chk_status("flush", 1'b1, 1'b0, 0);
    drain("flush");
    wv[0] = 16'sd20; wv[1] = 16'sd21;
    send_words(2, 2, 2, 1'b0);
    drain("len2");
    ack();

    // flush beats a last-word accept
    wv[0] = 16'sd30;
    send_words(2, 1, 2, 1'b0);
    tr_flush_i = 1'b1; tr_valid_i = 1'b1; tr_data_i = 16'sd31; tr_len_i = 4'd2;
    tick();
    tr_flush_i = 1'b0; tr_valid_i = 1'b0;
    chk_status("flush_last", 1'b1, 1'b0, 0);
    drain("flush_last");

    // 6: length 0 clamps to the full bank
    for (int i = 0; i < LEN; i++) wv[i] = tr_word_t'(-100 - i);
    send_words(0, 10, 10, 1'b0);
    drain("clamp");
    ack();

    // reset mid-frame zeroes the bank
    for (int i = 0; i < 5; i++) wv[i] = tr_word_t'(200 + i);
    send_words(10, 5, 10, 1'b0);
    drain("pre_rst");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < LEN; i++) model[i] = '0;
    chk_status("mid_rst", 1'b1, 1'b0, 0);
    drain("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
